// File: rtl/signal_encode.sv
// Run-length line encoder: each word bit is sent as bit_len samples at its level.
// Optional even-parity bit after the data when SIGNAL_ENCODE_PARITY_EN is defined.
module signal_encode #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 10,
    parameter int MSB_FIRST = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rdy,
    input  logic [CNT_W-1:0]  i_bit_len,
    input  logic [CNT_W-1:0]  i_gap_len,
    input  logic              i_tick,
    output logic              o_vld,
    output logic              o_vld_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PAR, GAP} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_len;
    logic [CNT_W-1:0]  gap_len;
    logic [CNT_W-1:0]  tick_cnt;
    logic [CNT_W-1:0]  gap_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              accept;
    logic              bit_end;
    logic              last_bit;
    logic              gap_end;
    logic              level;
    logic              in_bit;
    logic              vld_nx;
    logic              lvl_nx;
    logic              done_nx;
`ifdef SIGNAL_ENCODE_PARITY_EN
    logic              parity;
`endif

    assign accept   = (state == IDLE) & i_vld;
    assign bit_end  = i_tick & (tick_cnt == bit_len - CNT_W'(1));
    assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));
    assign gap_end  = (gap_cnt == gap_len);
    assign in_bit   = (state == DATA) | (state == PAR);
    assign o_rdy    = i_rst_n & (state == IDLE);
    assign o_busy   = (state != IDLE);

`ifdef SIGNAL_ENCODE_PARITY_EN
    assign level = (state == PAR) ? parity
                 : ((MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0]);
`else
    assign level = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = DATA;
            DATA: begin
                if (bit_end && last_bit) begin
`ifdef SIGNAL_ENCODE_PARITY_EN
                    state_nx = PAR;
`else
                    state_nx = GAP;
`endif
                end
            end
`ifdef SIGNAL_ENCODE_PARITY_EN
            PAR:  if (bit_end) state_nx = GAP;
`else
            PAR:  state_nx = IDLE;
`endif
            GAP:  if (gap_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // o_vld_data holds its level between ticks inside a bit run
    always_comb begin
        vld_nx  = 1'b0;
        lvl_nx  = 1'b0;
        done_nx = 1'b0;
        if (in_bit) begin
            vld_nx = i_tick;
            lvl_nx = i_tick ? level : o_vld_data;
        end
        if (state == GAP) done_nx = gap_end;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld      <= 1'b0;
            o_vld_data <= 1'b0;
            o_done     <= 1'b0;
            shreg      <= '0;
            bit_len    <= '0;
            gap_len    <= '0;
            tick_cnt   <= '0;
            gap_cnt    <= '0;
            bit_idx    <= '0;
`ifdef SIGNAL_ENCODE_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            o_vld      <= vld_nx;
            o_vld_data <= lvl_nx;
            o_done     <= done_nx;
            if (accept) begin
                shreg    <= i_data;
                bit_len  <= (i_bit_len == '0) ? CNT_W'(1) : i_bit_len;
                gap_len  <= i_gap_len;
                tick_cnt <= '0;
                gap_cnt  <= '0;
                bit_idx  <= '0;
`ifdef SIGNAL_ENCODE_PARITY_EN
                parity   <= ^i_data;
`endif
            end
            if (in_bit && i_tick) begin
                if (bit_end) begin
                    tick_cnt <= '0;
                    if (state == DATA) begin
                        shreg   <= (MSB_FIRST != 0)
                                 ? {shreg[DATA_W-2:0], 1'b0}
                                 : {1'b0, shreg[DATA_W-1:1]};
                        bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
                    end
                end else begin
                    tick_cnt <= tick_cnt + CNT_W'(1);
                end
            end
            if ((state == GAP) && !gap_end && i_tick)
                gap_cnt <= gap_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_signal_encode.sv
// Scoreboard bench for signal_encode: expected samples queued at accept.
// Define SIGNAL_ENCODE_PARITY_EN for both files to exercise the parity bit.
module tb_signal_encode;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_vld;
    logic [7:0] i_data;
    logic       o_rdy;
    logic [9:0] i_bit_len;
    logic [9:0] i_gap_len;
    logic       i_tick;
    logic       o_vld;
    logic       o_vld_data;
    logic       o_busy;
    logic       o_done;

`ifdef SIGNAL_ENCODE_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    int   n_vec  = 0;
    int   n_miss = 0;
    int   ncyc   = 0;
    int   last_vld = -1;
    int   nsamp  = 0;
    int   ndone  = 0;
    int   done_gap = 0;
    int   tick_mode = 0;
    logic exp_q[$];

    signal_encode #(.DATA_W(8), .CNT_W(10), .MSB_FIRST(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .i_data(i_data),
        .o_rdy(o_rdy), .i_bit_len(i_bit_len), .i_gap_len(i_gap_len),
        .i_tick(i_tick), .o_vld(o_vld), .o_vld_data(o_vld_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, ncyc);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input int bl);
        int b;
        b = (bl == 0) ? 1 : bl;
        for (int i = 7; i >= 0; i--)
            repeat (b) exp_q.push_back(d[i]);
`ifdef SIGNAL_ENCODE_PARITY_EN
        repeat (b) exp_q.push_back(^d);
`endif
    endtask

    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge i_clk);
            case (tick_mode)
                0:       i_tick = 1'b1;
                1:       i_tick = (tc % 3 == 0);
                default: i_tick = 1'($urandom_range(0, 1));
            endcase
            tc++;
        end
    end

    // sample monitor: pops the scoreboard on every valid output sample
    initial begin
        forever begin
            @(negedge i_clk);
            ncyc++;
            if (o_vld) begin
                if (exp_q.size() == 0) chk("extra_sample", 1, 0);
                else chk("sample", o_vld_data, exp_q.pop_front());
                if (tick_mode == 1) begin
                    chk("busy_in_frame", o_busy, 1);
                    if (last_vld >= 0) chk("spacing", ncyc - last_vld, 3);
                end
                last_vld = ncyc;
                nsamp++;
            end
            if (o_done) begin
                ndone++;
                done_gap = ncyc - last_vld;
            end
        end
    end

    task automatic wait_rdy();
        int k;
        k = 0;
        while (!o_rdy && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        chk("rdy_wait", o_rdy, 1);
    endtask

    task automatic send(input logic [7:0] d, input int bl, input int gl);
        wait_rdy();
        i_data    = d;
        i_bit_len = 10'(bl);
        i_gap_len = 10'(gl);
        i_vld     = 1'b1;
        push_word(d, bl);
        @(negedge i_clk);
        i_vld = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!o_done && k < 5000) begin
            @(negedge i_clk);
            k++;
        end
        chk("done", o_done, 1);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] d, input int bl,
                             input int gl, input bit chk_gap);
        int b;
        b = (bl == 0) ? 1 : bl;
        last_vld = -1;
        nsamp = 0;
        send(d, bl, gl);
        wait_done();
        chk("nsamp", nsamp, b * NB);
        chk("q_empty", exp_q.size(), 0);
        if (chk_gap) chk("done_gap", done_gap, gl + 1);
    endtask

    initial begin
        int d0;
        int k;
        #2_000_000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int k;
        i_rst_n = 1'b1;
        i_vld = 1'b0;
        i_data = '0;
        i_bit_len = '0;
        i_gap_len = '0;
        i_tick = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_data", o_vld_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_rdy", o_rdy, 1);

        run_frame(8'hA5, 4, 2, 1);
        run_frame(8'h01, 0, 0, 1);

        tick_mode = 1;
        run_frame(8'hFF, 2, 1, 0);
        tick_mode = 0;

        // hold i_vld with junk while busy; next word lands in the o_done cycle
        wait_rdy();
        i_data = 8'h3C; i_bit_len = 10'd1; i_gap_len = 10'd1; i_vld = 1'b1;
        push_word(8'h3C, 1);
        @(negedge i_clk);
        k = 0;
        while (!o_done && k < 500) begin
            i_data    = 8'($urandom);
            i_bit_len = 10'($urandom);
            i_gap_len = 10'($urandom);
            @(negedge i_clk);
            k++;
        end
        chk("hold_done", o_done, 1);
        chk("rdy_at_done", o_rdy, 1);
        i_data = 8'hC3; i_bit_len = 10'd1; i_gap_len = 10'd1;
        push_word(8'hC3, 1);
        @(negedge i_clk);
        chk("b2b_capture", o_rdy, 0);
        i_vld = 1'b0;
        @(negedge i_clk);
        chk("b2b_first", o_vld, 1);
        wait_done();
        chk("b2b_q_empty", exp_q.size(), 0);

        last_vld = -1;
        nsamp = 0;
        send(8'hFF, 2, 1);
        k = 0;
        while (nsamp < 5 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", o_vld, 0);
        chk("mid_rst_data", o_vld_data, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_done", o_done, 0);
        exp_q.delete();
        d0 = ndone;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_rdy", o_rdy, 1);
        repeat (30) @(negedge i_clk);
        chk("mid_rst_no_done", ndone, d0);

`ifdef SIGNAL_ENCODE_PARITY_EN
        run_frame(8'h07, 3, 1, 1);
        run_frame(8'h03, 3, 1, 1);
`endif

        tick_mode = 2;
        for (int i = 0; i < 4; i++)
            run_frame(8'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 0);
        tick_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
